switch_port_checker: RTL and testbench

//  Synthesisable, passive packet-rule checker for one input port of the N-port switch.

---
 rtl/switch_port_checker.sv | 201 ++++++++++++++++++++
 tb/tb_switch_port_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_checker.sv
// Passive packet-rule checker for one switch input port: frames packets on valid_ip,
// classifies each one, checks the source/target/length rules and keeps saturating statistics.
module switch_port_checker #(
    parameter int unsigned NPORTS  = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned MAX_LEN = 15,
    parameter int unsigned CW      = 16,
    localparam int unsigned LW     = $clog2(MAX_LEN + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ip,
    input  logic              suspend_ip,
    input  logic [DW-1:0]     data_ip,
    input  logic              clr_counts,
    output logic              pkt_valid,
    output logic [1:0]        pkt_type,
    output logic [NPORTS-1:0] pkt_src,
    output logic [NPORTS-1:0] pkt_tgt,
    output logic [LW-1:0]     pkt_len,
    output logic              pkt_err,
    output logic [4:0]        err_code,
    output logic [CW-1:0]     cnt_single,
    output logic [CW-1:0]     cnt_multi,
    output logic [CW-1:0]     cnt_bcast,
    output logic [CW-1:0]     cnt_err
);

    localparam logic [1:0]    TypeSingle  = 2'd0;
    localparam logic [1:0]    TypeMulti   = 2'd1;
    localparam logic [1:0]    TypeBcast   = 2'd2;
    localparam logic [1:0]    TypeInvalid = 2'd3;
    localparam logic [LW-1:0] LenClamp    = LW'(MAX_LEN + 1);
    localparam logic [LW-1:0] LenMin      = LW'(MIN_LEN);
    localparam logic [LW-1:0] LenMax      = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StBody
    } state_e;

    function automatic int unsigned popcount(input logic [NPORTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [NPORTS-1:0] src_q, src_d;
    logic [NPORTS-1:0] tgt_q, tgt_d;
    logic [LW-1:0]     len_q, len_d;
    logic              eop;
    logic              beat;

    logic              pkt_valid_q;
    logic [1:0]        pkt_type_q;
    logic [NPORTS-1:0] pkt_src_q;
    logic [NPORTS-1:0] pkt_tgt_q;
    logic [LW-1:0]     pkt_len_q;
    logic [4:0]        err_code_q;
    logic [CW-1:0]     cnt_single_q, cnt_multi_q, cnt_bcast_q, cnt_err_q;

    logic [1:0]        new_type;
    logic [4:0]        new_err;

    assign beat = valid_ip & ~suspend_ip;

    // Framing FSM. Suspended cycles leave state and length untouched; only valid_ip frames.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        eop     = 1'b0;
        unique case (state_q)
            StSync: begin
                if (!valid_ip) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (beat) begin
                    src_d   = data_ip[NPORTS-1:0];
                    tgt_d   = data_ip[2*NPORTS-1:NPORTS];
                    len_d   = '0;
                    state_d = StBody;
                end
            end
            StBody: begin
                if (!valid_ip) begin
                    state_d = StIdle;
                    eop     = 1'b1;
                end else if (!suspend_ip && len_q != LenClamp) begin
                    len_d = len_q + 1'b1;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSync;
            src_q   <= '0;
            tgt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
        end
    end

    // Classification and rule checks on the captured header and final length.
    always_comb begin
        new_type = TypeMulti;
        new_err  = '0;
        if (&tgt_q) begin
            new_type = TypeBcast;
        end else if (popcount(tgt_q) == 1) begin
            new_type = TypeSingle;
        end else if (tgt_q == '0) begin
            new_type = TypeInvalid;
        end
        new_err[0] = (popcount(src_q) != 1);
        new_err[1] = (tgt_q == '0);
        new_err[2] = (|(src_q & tgt_q)) && (new_type != TypeBcast);
        new_err[3] = (len_q < LenMin);
        new_err[4] = (len_q > LenMax);
    end

    // Result registers: pulse plus fields that hold until the next packet ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_valid_q <= 1'b0;
            pkt_type_q  <= '0;
            pkt_src_q   <= '0;
            pkt_tgt_q   <= '0;
            pkt_len_q   <= '0;
            err_code_q  <= '0;
        end else begin
            pkt_valid_q <= eop;
            if (eop) begin
                pkt_type_q <= new_type;
                pkt_src_q  <= src_q;
                pkt_tgt_q  <= tgt_q;
                pkt_len_q  <= len_q;
                err_code_q <= new_err;
            end
        end
    end

    // Counters move on the same edge that raises pkt_valid, so they are current with the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_single_q <= '0;
            cnt_multi_q  <= '0;
            cnt_bcast_q  <= '0;
            cnt_err_q    <= '0;
        end else if (clr_counts) begin
            cnt_single_q <= '0;
            cnt_multi_q  <= '0;
            cnt_bcast_q  <= '0;
            cnt_err_q    <= '0;
        end else if (eop) begin
            if (|new_err) begin
                cnt_err_q <= sat_inc(cnt_err_q);
            end else begin
                unique case (new_type)
                    TypeSingle: cnt_single_q <= sat_inc(cnt_single_q);
                    TypeMulti:  cnt_multi_q  <= sat_inc(cnt_multi_q);
                    TypeBcast:  cnt_bcast_q  <= sat_inc(cnt_bcast_q);
                    default:    ;
                endcase
            end
        end
    end

    assign pkt_valid  = pkt_valid_q;
    assign pkt_type   = pkt_type_q;
    assign pkt_src    = pkt_src_q;
    assign pkt_tgt    = pkt_tgt_q;
    assign pkt_len    = pkt_len_q;
    assign err_code   = err_code_q;
    assign pkt_err    = pkt_valid_q & (|err_code_q);
    assign cnt_single = cnt_single_q;
    assign cnt_multi  = cnt_multi_q;
    assign cnt_bcast  = cnt_bcast_q;
    assign cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_switch_port_checker.sv
// Directed bench for switch_port_checker (NPORTS=4, DW=8, MIN_LEN=1, MAX_LEN=4, CW=3).
module tb_switch_port_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_ip;
    logic       suspend_ip;
    logic [7:0] data_ip;
    logic       clr_counts;
    logic       pkt_valid;
    logic [1:0] pkt_type;
    logic [3:0] pkt_src;
    logic [3:0] pkt_tgt;
    logic [2:0] pkt_len;
    logic       pkt_err;
    logic [4:0] err_code;
    logic [2:0] cnt_single, cnt_multi, cnt_bcast, cnt_err;

    int n_total = 0;
    int n_bad   = 0;
    int pulses  = 0;
    int pc0;

    switch_port_checker #(
        .NPORTS (4),
        .DW     (8),
        .MIN_LEN(1),
        .MAX_LEN(4),
        .CW     (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_ip  (valid_ip),
        .suspend_ip(suspend_ip),
        .data_ip   (data_ip),
        .clr_counts(clr_counts),
        .pkt_valid (pkt_valid),
        .pkt_type  (pkt_type),
        .pkt_src   (pkt_src),
        .pkt_tgt   (pkt_tgt),
        .pkt_len   (pkt_len),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .cnt_single(cnt_single),
        .cnt_multi (cnt_multi),
        .cnt_bcast (cnt_bcast),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives header + payload, then the end cycle; returns just after the pulse edge.
    task automatic send_pkt(input logic [7:0] hdr, input int nbeats, input int susp_at,
                            input int susp_n, input logic clr_end);
        valid_ip   = 1'b1;
        suspend_ip = 1'b0;
        data_ip    = hdr;
        step();
        for (int i = 0; i < nbeats; i++) begin
            if (i == susp_at) begin
                suspend_ip = 1'b1;
                data_ip    = 8'hEE;
                repeat (susp_n) step();
                suspend_ip = 1'b0;
            end
            data_ip = 8'(i + 1);
            step();
        end
        valid_ip   = 1'b0;
        data_ip    = 8'h00;
        clr_counts = clr_end;
        step();
    endtask

    task automatic check_pkt(input string tag, input int typ, input int src, input int tgt,
                             input int len, input int code);
        check_eq({tag, ".valid"}, 32'(pkt_valid), 1);
        check_eq({tag, ".type"}, 32'(pkt_type), 32'(typ));
        check_eq({tag, ".src"}, 32'(pkt_src), 32'(src));
        check_eq({tag, ".tgt"}, 32'(pkt_tgt), 32'(tgt));
        check_eq({tag, ".len"}, 32'(pkt_len), 32'(len));
        check_eq({tag, ".code"}, 32'(err_code), 32'(code));
        check_eq({tag, ".err"}, 32'(pkt_err), (code != 0) ? 1 : 0);
    endtask

    task automatic check_cnts(input string tag, input int s, input int m, input int b, input int e);
        check_eq({tag, ".single"}, 32'(cnt_single), 32'(s));
        check_eq({tag, ".multi"}, 32'(cnt_multi), 32'(m));
        check_eq({tag, ".bcast"}, 32'(cnt_bcast), 32'(b));
        check_eq({tag, ".cerr"}, 32'(cnt_err), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        valid_ip   = 1'b0;
        suspend_ip = 1'b0;
        data_ip    = 8'h00;
        clr_counts = 1'b0;
        step();
        step();
        check_eq("rst.valid", 32'(pkt_valid), 0);
        check_eq("rst.len", 32'(pkt_len), 0);
        check_eq("rst.code", 32'(err_code), 0);
        check_cnts("rst", 0, 0, 0, 0);
        reset = 1'b0;
        step();

        // 1: single
        send_pkt(8'h21, 3, -1, 0, 1'b0);
        check_pkt("t1", 0, 1, 2, 3, 0);
        step();
        check_eq("t1.pulse_end", 32'(pkt_valid), 0);
        check_eq("t1.hold_len", 32'(pkt_len), 3);
        check_cnts("t1", 1, 0, 0, 0);

        // 2: broadcast, overlap allowed
        send_pkt(8'hF2, 1, -1, 0, 1'b0);
        check_pkt("t2", 2, 2, 15, 1, 0);
        step();
        check_cnts("t2", 1, 0, 1, 0);

        // 3: multicast with overlap
        send_pkt(8'h31, 2, -1, 0, 1'b0);
        check_pkt("t3", 1, 1, 3, 2, 4);
        step();
        check_eq("t3.err_low", 32'(pkt_err), 0);
        check_eq("t3.hold_code", 32'(err_code), 4);
        check_cnts("t3", 1, 0, 1, 1);

        // 4a/4b/4c: short then long, back-to-back
        pc0 = pulses;
        send_pkt(8'h21, 0, -1, 0, 1'b0);
        check_pkt("t4a", 0, 1, 2, 0, 8);
        send_pkt(8'h21, 6, -1, 0, 1'b0);
        check_pkt("t4b", 0, 1, 2, 5, 16);
        step();
        check_eq("t4c.pulses", 32'(pulses - pc0), 2);
        check_cnts("t4", 1, 0, 1, 3);

        // 5: suspend mid-payload
        send_pkt(8'h84, 3, 1, 2, 1'b0);
        check_pkt("t5", 0, 4, 8, 3, 0);
        step();
        check_cnts("t5", 2, 0, 1, 3);

        // clear coincident with an increment
        send_pkt(8'h21, 1, -1, 0, 1'b1);
        check_pkt("clr", 0, 1, 2, 1, 0);
        step();
        clr_counts = 1'b0;
        check_cnts("clr", 0, 0, 0, 0);

        // 6: reset mid-payload while valid_ip stays high
        pc0        = pulses;
        valid_ip   = 1'b1;
        data_ip    = 8'h21;
        step();
        data_ip    = 8'h01;
        step();
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        data_ip    = 8'h02;
        step();
        step();
        valid_ip   = 1'b0;
        step();
        step();
        check_eq("t6.no_pulse", 32'(pulses - pc0), 0);
        check_eq("t6.len_rst", 32'(pkt_len), 0);
        send_pkt(8'h12, 1, -1, 0, 1'b0);
        check_pkt("t6", 0, 2, 1, 1, 0);
        step();
        check_eq("t6.pulses", 32'(pulses - pc0), 1);
        check_cnts("t6", 1, 0, 0, 0);

        // saturation of cnt_err (CW=3)
        for (int i = 0; i < 9; i++) begin
            send_pkt(8'h21, 0, -1, 0, 1'b0);
        end
        step();
        check_cnts("sat", 1, 0, 0, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
